// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two requesters share one full-adder cell, arbitrated
// round-robin; each grant adds LSB-first over WIDTH cycles with a registered carry.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             owner
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, r_q, r_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, owner_q, owner_d, last_q, last_d, cout_q, cout_d;
  logic any_req, grant1, last_bit, s, carry;
  assign any_req  = req0 | req1;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant1   = req1 & (~req0 | ~last_q);
  assign last_bit = cnt_q == CW'(WIDTH - 1);
  assign s        = sa_q[0] ^ sb_q[0] ^ c_q;
  assign carry    = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && any_req) state_d = RUN;
    else if (state_q == RUN && last_bit) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    owner_d = owner_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == IDLE && any_req) begin
      sa_d    = grant1 ? a1 : a0;
      sb_d    = grant1 ? b1 : b0;
      c_d     = grant1 ? cin1 : cin0;
      cnt_d   = '0;
      owner_d = grant1;
    end else if (state_q == RUN) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      r_d   = {s, r_q[WIDTH-1:1]};
      c_d   = carry;
      cnt_d = cnt_q + CW'(1);
      // Publish on the final bit edge so the result is valid alongside ack.
      sum_d  = last_bit ? r_d : sum_q;
      cout_d = last_bit ? carry : cout_q;
    end else if (state_q == DONE) begin
      last_d = owner_q;
    end
  end
  always_comb begin
    ack0 = state_q == DONE && !owner_q;
    ack1 = state_q == DONE && owner_q;
    busy = state_q != IDLE;
  end
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed and random checks of the shared serial adder
// against an arithmetic round-robin reference.
module tb_serial_add_arbiter;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic ack0, ack1, cout, busy, owner;
  logic [W-1:0] sum;
  int tests = 0, fails = 0;
  bit last_m = 1'b1;
  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout), .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Called at a falling edge with the DUT idle and at least one request up.
  task automatic run_op(input string tag, input bit scr, input bit drop);
    bit w;
    logic [W:0] e;
    int n;
    bit got;
    chk({tag, "_idle"}, busy, 0);
    w = (req0 && req1) ? !last_m : req1;
    e = w ? a1 + b1 + cin1 : a0 + b0 + cin0;
    n = 0;
    got = 0;
    while (!got && n < 3 * W) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) got = 1;
      else begin
        if (!busy) chk({tag, "_busy_run"}, busy, 1);
        if (n == 1 && scr) begin
          if (w) begin a1 = '0; b1 = '0; cin1 = ~cin1; end
          else begin a0 = '0; b0 = '0; cin0 = ~cin0; end
        end
        if (n == 3 && drop) begin
          if (w) req1 = 0; else req0 = 0;
        end
      end
    end
    chk({tag, "_lat"}, n, W + 1);
    chk({tag, "_acks"}, {ack1, ack0}, w ? 2'b10 : 2'b01);
    chk({tag, "_res"}, {cout, sum}, e);
    chk({tag, "_owner"}, owner, w);
    chk({tag, "_busy_done"}, busy, 1);
    if (w) req1 = 0; else req0 = 0;
    last_m = w;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    req0 = 1; a0 = 8'h5A; b0 = 8'h3C; cin0 = 0;
    run_op("t1", 0, 0);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
    req1 = 1; a1 = 8'hFF; b1 = 8'h01; cin1 = 0;
    run_op("t2a", 0, 0);
    chk("t2a_res", {cout, sum}, 9'h100);
    req1 = 1; a1 = 8'hFF; b1 = 8'h00; cin1 = 1;
    run_op("t2b", 0, 0);
    chk("t2b_res", {cout, sum}, 9'h100);
    chk("hold_sum", sum, 8'h00);
    req0 = 1; a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
    req1 = 1; a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      run_op("rr", 0, 0);
      chk("rr_order", owner, i % 2);
      if (i % 2 == 0) begin req0 = 1; a0 = W'($urandom); b0 = W'($urandom); end
      else begin req1 = 1; a1 = W'($urandom); b1 = W'($urandom); end
    end
    while (req0 || req1) run_op("rr_drain", 0, 0);
    req0 = 1; a0 = 8'h77; b0 = 8'h99; cin0 = 1;
    run_op("scr", 1, 1);
    chk("scr_res", {cout, sum}, 9'h111);
    req0 = 1; a0 = 8'hAB; b0 = 8'hCD; cin0 = 0;
    repeat (5) @(negedge clk);
    rst = 1; req0 = 0;
    @(negedge clk);
    rst = 0;
    last_m = 1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 0);
    for (int i = 0; i < W + 2; i++) begin
      chk("mid_rst_noack", {ack1, ack0}, 0);
      @(negedge clk);
    end
    req0 = 1; a0 = 8'h12; b0 = 8'h34; cin0 = 0;
    run_op("post_rst", 0, 0);
    chk("post_rst_sum", sum, 8'h46);
    for (int k = 0; k < 1000; k++) begin
      if (!req0 && $urandom_range(1)) begin req0 = 1; a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom); end
      if (!req1 && $urandom_range(1)) begin req1 = 1; a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom); end
      if (!req0 && !req1) begin req1 = 1; a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom); end
      run_op("rnd", 1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
